ahb_default_slave_param: RTL and testbench
==========================================

Name: ahb_default_slave_param

Overview:
- Parametrised AHB-Lite default slave, selected by the decoder when no other slave claims HADDR.
- Answers IDLE/BUSY transfers with a zero-wait OKAY.
- Answers NONSEQ/SEQ transfers with a configurable number of wait states, then the two-cycle ERROR response.
- Keeps a sideband fault log (saturating count, last faulting address and direction, interrupt pulse) for the debug/interrupt controller.

Parameters:
- DATA_WIDTH, 64, HRDATA/HWDATA width; legal values 32, 64, 128.
- ADDR_WIDTH, 32, HADDR and err_addr width.
- WAIT_STATES, 0, wait cycles (HREADYOUT=0, HRESP=0) inserted before the ERROR response; range 0..15.
- CNT_WIDTH, 8, width of the saturating fault counter.
- RDATA_FILL, 64'hDEAD_BEEF_DEAD_BEEF, constant driven on HRDATA, truncated to DATA_WIDTH.

Ports:
- HCLK  in  1  bus clock.
- HRESET  in  1  synchronous reset, active-high.
- HSEL  in  1  slave select from decoder.
- HREADY  in  1  bus-level ready; address phase sampled only when HSEL&HREADY.
- HTRANS  in  2  transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HWRITE  in  1  transfer direction.
- HADDR  in  ADDR_WIDTH  transfer address.
- HSIZE, HBURST  in  3 each  ignored except for lint; not stored.
- HPROT  in  4  ignored.
- HMASTLOCK  in  1  ignored.
- HWDATA  in  DATA_WIDTH  ignored.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  DATA_WIDTH  always RDATA_FILL.
- err_clear  in  1  synchronous clear of err_count.
- err_count  out  CNT_WIDTH  number of faulted transfers, saturating.
- err_addr  out  ADDR_WIDTH  HADDR of the most recent faulted transfer.
- err_write  out  1  HWRITE of the most recent faulted transfer.
- err_irq  out  1  one-cycle pulse in the ERR2 cycle of each faulted transfer.

Behaviour:
- Reset (HRESET=1 at a rising HCLK edge, any state):
  - state=IDLE, HREADYOUT=1, HRESP=0.
  - err_count=0, err_addr=0, err_write=0, err_irq=0.
  - Any transfer in progress is abandoned.
- Outputs are registered from the state except HRDATA, which is constant.
- A valid fault means HSEL & HREADY & HTRANS[1] sampled at a rising edge.
- States:
  - IDLE: HREADYOUT=1, HRESP=0.
    - Valid fault -> WAIT if WAIT_STATES>0 (wait counter loaded WAIT_STATES-1), else ERR1.
    - Otherwise stay, including HTRANS=IDLE/BUSY (OKAY, zero wait).
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements; at 0 -> ERR1. Inputs are ignored (transfer committed).
  - ERR1: HREADYOUT=0, HRESP=1. Unconditional -> ERR2. A master change of HTRANS to IDLE does not shorten the response.
  - ERR2: HREADYOUT=1, HRESP=1, err_irq=1.
    - HREADY is high here, so a new valid fault sampled in this cycle -> WAIT/ERR1 directly (back-to-back errors, no IDLE bubble).
    - Otherwise -> IDLE.
- Fault capture:
  - err_addr/err_write are latched on the edge that accepts the faulting address phase.
  - err_count increments on entry to ERR2 and saturates at 2^CNT_WIDTH-1.
  - err_clear in the same cycle as an increment: count becomes 1.
  - err_clear alone: count becomes 0.
  - err_addr/err_write are not affected by err_clear.
- Latency of a faulted transfer: WAIT_STATES+2 cycles from address-phase acceptance to the ERR2 cycle.
- HSEL low or HREADY low in IDLE: no state change.

Decomposition:
- Package ahb_pkg holds:
  - htrans_t enum (IDLE, BUSY, NONSEQ, SEQ).
  - hresp constants OKAY/ERROR.
  - dslv_state_t enum (IDLE, WAIT, ERR1, ERR2).
- One sub-module, ahb_fault_log: saturating counter plus address/direction capture, driven by capture/increment strobes from the FSM.

Test Plan:
- HRESET=1 for 2 cycles, then 0 -> HREADYOUT=1, HRESP=0, err_count=0, HRDATA=RDATA_FILL.
- HSEL=1, HTRANS=01 (BUSY) then 00 for 4 cycles -> HREADYOUT=1, HRESP=0 every cycle, err_count stays 0.
- WAIT_STATES=0, NONSEQ write to HADDR=32'h0000_1000:
  - next cycle HREADYOUT=0/HRESP=1;
  - then HREADYOUT=1/HRESP=1 with err_irq=1;
  - err_count=1, err_addr=32'h1000, err_write=1.
- WAIT_STATES=3, NONSEQ read to 32'h8000_0004 -> 3 cycles HREADYOUT=0/HRESP=0, then ERR1, then ERR2; err_write=0.
- Back-to-back NONSEQ at 32'h10, then SEQ at 32'h14 presented in the ERR2 cycle -> second ERR1 immediately follows; err_count=2, err_addr=32'h14.
- CNT_WIDTH=2 with 5 faults -> err_count saturates at 3.
- err_clear asserted in the ERR2 cycle of a fault -> err_count=1.
- HRESET asserted during ERR1 -> next cycle HREADYOUT=1, HRESP=0, err_count=0.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite transfer/response encodings and default-slave FSM states.
package ahb_pkg;
   typedef enum logic [1:0] {
      TR_IDLE   = 2'b00,
      TR_BUSY   = 2'b01,
      TR_NONSEQ = 2'b10,
      TR_SEQ    = 2'b11
   } htrans_t;
   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } dslv_state_t;
endpackage

// File: rtl/ahb_fault_log.sv
// ahb_fault_log: saturating fault counter with last-fault address/direction capture.
module ahb_fault_log #(
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_cap,
   input  logic                  i_inc,
   input  logic                  i_clr,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic                  i_write,
   output logic [CNT_WIDTH-1:0]  o_count,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic                  o_write
);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   logic [CNT_WIDTH-1:0]  r_count;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_write;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
         r_addr  <= '0;
         r_write <= 1'b0;
      end else begin
         if (i_cap) begin
            r_addr  <= i_addr;
            r_write <= i_write;
         end
         // a clear coinciding with a new fault still records that fault
         if (i_clr)
            r_count <= i_inc ? CNT_WIDTH'(1) : '0;
         else if (i_inc && r_count != CNT_MAX)
            r_count <= r_count + CNT_WIDTH'(1);
      end
   end
   assign o_count = r_count;
   assign o_addr  = r_addr;
   assign o_write = r_write;
endmodule

// File: rtl/ahb_default_slave_param.sv
// ahb_default_slave_param: AHB-Lite default slave; OKAY for IDLE/BUSY, wait states then
// two-cycle ERROR for NONSEQ/SEQ, with a sideband fault log.
module ahb_default_slave_param
   import ahb_pkg::*;
#(
   parameter int              DATA_WIDTH  = 64,
   parameter int              ADDR_WIDTH  = 32,
   parameter int              WAIT_STATES = 0,
   parameter int              CNT_WIDTH   = 8,
   parameter logic [63:0]     RDATA_FILL  = 64'hDEAD_BEEF_DEAD_BEEF
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic                  HREADY,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [3:0]            HPROT,
   input  logic                  HMASTLOCK,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [DATA_WIDTH-1:0] HRDATA,
   input  logic                  err_clear,
   output logic [CNT_WIDTH-1:0]  err_count,
   output logic [ADDR_WIDTH-1:0] err_addr,
   output logic                  err_write,
   output logic                  err_irq
);
   localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
   dslv_state_t r_state, w_next;
   logic [3:0]  r_wcnt, w_wcnt;
   htrans_t     w_trans;
   logic        w_fault, w_cap, w_inc, w_unused;
   assign w_trans  = htrans_t'(HTRANS);
   assign w_fault  = HSEL & HREADY & (w_trans == TR_NONSEQ || w_trans == TR_SEQ);
   assign w_unused = ^{HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA};
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state <= ST_IDLE;
         r_wcnt  <= '0;
      end else begin
         r_state <= w_next;
         r_wcnt  <= w_wcnt;
      end
   end
   // address phases are only accepted while HREADYOUT is high (IDLE and ERR2)
   always_comb begin
      w_next = r_state;
      w_wcnt = r_wcnt;
      w_cap  = 1'b0;
      w_inc  = 1'b0;
      case (r_state)
         ST_IDLE, ST_ERR2: begin
            w_cap  = w_fault;
            w_wcnt = WS_LOAD;
            w_next = w_fault ? ((WAIT_STATES > 0) ? ST_WAIT : ST_ERR1) : ST_IDLE;
         end
         ST_WAIT: begin
            w_next = (r_wcnt == 4'd0) ? ST_ERR1 : ST_WAIT;
            w_wcnt = r_wcnt - 4'd1;
         end
         ST_ERR1: begin
            w_next = ST_ERR2;
            w_inc  = 1'b1;
         end
         default: w_next = ST_IDLE;
      endcase
   end
   assign HREADYOUT = (r_state == ST_IDLE) || (r_state == ST_ERR2);
   assign HRESP     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
   assign err_irq   = (r_state == ST_ERR2);
   assign HRDATA    = DATA_WIDTH'(RDATA_FILL);
   ahb_fault_log #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_log (
      .i_clk  (HCLK),
      .i_rst  (HRESET),
      .i_cap  (w_cap),
      .i_inc  (w_inc),
      .i_clr  (err_clear),
      .i_addr (HADDR),
      .i_write(HWRITE),
      .o_count(err_count),
      .o_addr (err_addr),
      .o_write(err_write)
   );
endmodule

// File: tb/tb_ahb_default_slave_param.sv
// tb_ahb_default_slave_param: directed checks on three configurations sharing one bus,
// each selected by its own HSEL.
module tb_ahb_default_slave_param;
   logic clk = 1'b0;
   logic rst, hready, hwrite, clr;
   logic sel0, sel3, sel2;
   logic [1:0]  htrans;
   logic [31:0] haddr;
   int n_cmp = 0;
   int n_err = 0;

   logic        rdy0, rsp0, wr0, irq0;
   logic [63:0] rd0;
   logic [7:0]  cnt0;
   logic [31:0] ea0;
   logic        rdy3, rsp3, wr3, irq3;
   logic [63:0] rd3;
   logic [7:0]  cnt3;
   logic [31:0] ea3;
   logic        rdy2, rsp2, wr2, irq2;
   logic [31:0] rd2;
   logic [1:0]  cnt2;
   logic [31:0] ea2;

   always #5 clk = ~clk;

   ahb_default_slave_param #(.WAIT_STATES(0)) u0 (
      .HCLK(clk), .HRESET(rst), .HSEL(sel0), .HREADY(hready), .HTRANS(htrans),
      .HWRITE(hwrite), .HADDR(haddr), .HSIZE(3'd3), .HBURST(3'd0), .HPROT(4'd0),
      .HMASTLOCK(1'b0), .HWDATA(64'd0), .HREADYOUT(rdy0), .HRESP(rsp0), .HRDATA(rd0),
      .err_clear(clr), .err_count(cnt0), .err_addr(ea0), .err_write(wr0), .err_irq(irq0));
   ahb_default_slave_param #(.WAIT_STATES(3)) u3 (
      .HCLK(clk), .HRESET(rst), .HSEL(sel3), .HREADY(hready), .HTRANS(htrans),
      .HWRITE(hwrite), .HADDR(haddr), .HSIZE(3'd3), .HBURST(3'd0), .HPROT(4'd0),
      .HMASTLOCK(1'b0), .HWDATA(64'd0), .HREADYOUT(rdy3), .HRESP(rsp3), .HRDATA(rd3),
      .err_clear(clr), .err_count(cnt3), .err_addr(ea3), .err_write(wr3), .err_irq(irq3));
   ahb_default_slave_param #(.DATA_WIDTH(32), .WAIT_STATES(0), .CNT_WIDTH(2)) u2 (
      .HCLK(clk), .HRESET(rst), .HSEL(sel2), .HREADY(hready), .HTRANS(htrans),
      .HWRITE(hwrite), .HADDR(haddr), .HSIZE(3'd2), .HBURST(3'd0), .HPROT(4'd0),
      .HMASTLOCK(1'b0), .HWDATA(32'd0), .HREADYOUT(rdy2), .HRESP(rsp2), .HRDATA(rd2),
      .err_clear(clr), .err_count(cnt2), .err_addr(ea2), .err_write(wr2), .err_irq(irq2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; hready = 1'b1; hwrite = 1'b0; clr = 1'b0;
      sel0 = 1'b0; sel3 = 1'b0; sel2 = 1'b0; htrans = 2'b00; haddr = '0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_rdy", rdy0, 1); chk("rst_rsp", rsp0, 0); chk("rst_cnt", cnt0, 0);
      chk("rst_irq", irq0, 0); chk("rst_ea", ea0, 0); chk("rst_wr", wr0, 0);
      chk("rst_rdata", rd0, 64'hDEAD_BEEF_DEAD_BEEF);
      chk("rdata_trunc", rd2, 32'hDEAD_BEEF);

      // BUSY then IDLE: zero-wait OKAY
      sel0 = 1'b1; htrans = 2'b01; haddr = 32'h40;
      tick();
      chk("busy_rdy", rdy0, 1); chk("busy_rsp", rsp0, 0);
      htrans = 2'b00;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("idle_rdy", rdy0, 1); chk("idle_rsp", rsp0, 0);
      end
      chk("idle_cnt", cnt0, 0);

      // HREADY low in IDLE: NONSEQ not sampled
      hready = 1'b0; htrans = 2'b10;
      tick();
      chk("nrdy_rdy", rdy0, 1); chk("nrdy_rsp", rsp0, 0);
      hready = 1'b1; htrans = 2'b00;

      // WAIT_STATES=0 NONSEQ write
      htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0000_1000;
      tick();
      htrans = 2'b00;
      chk("w0_e1_rdy", rdy0, 0); chk("w0_e1_rsp", rsp0, 1); chk("w0_e1_irq", irq0, 0);
      tick();
      chk("w0_e2_rdy", rdy0, 1); chk("w0_e2_rsp", rsp0, 1); chk("w0_e2_irq", irq0, 1);
      chk("w0_cnt", cnt0, 1); chk("w0_ea", ea0, 32'h1000); chk("w0_wr", wr0, 1);
      tick();
      chk("w0_done_rdy", rdy0, 1); chk("w0_done_rsp", rsp0, 0); chk("w0_done_irq", irq0, 0);

      // WAIT_STATES=3 NONSEQ read
      sel0 = 1'b0; sel3 = 1'b1;
      htrans = 2'b10; hwrite = 1'b0; haddr = 32'h8000_0004;
      tick();
      htrans = 2'b00;
      for (int i = 0; i < 3; i++) begin
         chk("w3_wait_rdy", rdy3, 0); chk("w3_wait_rsp", rsp3, 0);
         tick();
      end
      chk("w3_e1_rdy", rdy3, 0); chk("w3_e1_rsp", rsp3, 1);
      tick();
      chk("w3_e2_rdy", rdy3, 1); chk("w3_e2_rsp", rsp3, 1); chk("w3_e2_irq", irq3, 1);
      chk("w3_cnt", cnt3, 1); chk("w3_ea", ea3, 32'h8000_0004); chk("w3_wr", wr3, 0);
      tick();
      chk("w3_done_rsp", rsp3, 0);
      sel3 = 1'b0;

      // back-to-back: NONSEQ 0x10, SEQ 0x14 presented in ERR2
      sel0 = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h10;
      tick();
      htrans = 2'b00;
      tick();
      chk("b2b_e2_irq", irq0, 1); chk("b2b_cnt1", cnt0, 2); chk("b2b_ea1", ea0, 32'h10);
      htrans = 2'b11; hwrite = 1'b0; haddr = 32'h14;
      tick();
      htrans = 2'b00;
      chk("b2b_e1_rdy", rdy0, 0); chk("b2b_e1_rsp", rsp0, 1);
      chk("b2b_ea2", ea0, 32'h14); chk("b2b_wr2", wr0, 0);
      tick();
      chk("b2b_cnt2", cnt0, 3);
      tick();
      chk("b2b_idle_rsp", rsp0, 0);
      chk("u3_unsel_cnt", cnt3, 1); chk("u3_unsel_rdy", rdy3, 1);

      // CNT_WIDTH=2 saturation
      sel0 = 1'b0; sel2 = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         htrans = 2'b10; hwrite = 1'b1; haddr = 32'(i * 4);
         tick();
         htrans = 2'b00;
         tick(); tick();
         chk("sat_cnt", cnt2, (i > 3) ? 3 : i);
      end
      chk("sat_ea", ea2, 32'd20);
      sel2 = 1'b0;

      // clear coinciding with the increment, then clear alone
      sel0 = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h20;
      tick();
      htrans = 2'b00; clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_inc_cnt", cnt0, 1); chk("clr_inc_irq", irq0, 1);
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_cnt", cnt0, 0); chk("clr_ea", ea0, 32'h20); chk("clr_wr", wr0, 1);

      // reset during ERR1
      htrans = 2'b10; haddr = 32'h30;
      tick();
      htrans = 2'b00;
      tick(); tick();
      chk("pre_rst_cnt", cnt0, 1);
      htrans = 2'b10; haddr = 32'h34;
      tick();
      htrans = 2'b00;
      chk("rst_e1_rsp", rsp0, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_e1_rdy", rdy0, 1); chk("rst_e1_rsp0", rsp0, 0);
      chk("rst_e1_cnt", cnt0, 0); chk("rst_e1_ea", ea0, 0);
      tick();
      chk("post_rst_rsp", rsp0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
